// File: rtl/porta_pad_scan.sv
// Dual SNES-style gamepad scanner with per-pad debounce, driving the active-low ColecoVision controller lines.
// Optional feature: define PORTA_PAD_TURBO_EN for L+R auto-fire on B/A.

module porta_pad_lane #(
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic        clk,
  input  logic        RESETn,
  input  logic        i_commit,
  input  logic [11:0] i_scan,
  input  logic        i_c4,
  input  logic        i_c7,
  output logic [5:0]  o_lines
);
  localparam logic [2:0] DB = 3'(DEBOUNCE_SCANS);

  logic [11:0] r_cand, r_stable;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic        w_b, w_a, w_l, w_r;
  logic [3:0]  w_nib;
  logic [5:0]  w_j, w_k;

  assign w_cnt_nxt = (i_scan != r_cand) ? 3'd1 :
                     (r_cnt == 3'd7)    ? r_cnt : r_cnt + 3'd1;

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_cand   <= '1;
      r_stable <= '1;
      r_cnt    <= '0;
    end else if (i_commit) begin
      r_cand <= i_scan;
      r_cnt  <= w_cnt_nxt;
      if (w_cnt_nxt >= DB) r_stable <= i_scan;
    end
  end

`ifdef PORTA_PAD_TURBO_EN
  logic [1:0] r_tcnt;
  logic       r_tog;
  logic       w_combo;

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_tcnt <= '0;
      r_tog  <= 1'b0;
    end else if (i_commit) begin
      r_tcnt <= r_tcnt + 2'd1;
      if (r_tcnt == 2'd3) r_tog <= ~r_tog;
    end
  end

  // Held L+R forces fire to read released on alternate 4-scan runs and hides the L/R keys.
  assign w_combo = ~r_stable[10] & ~r_stable[11];
  assign w_b     = r_stable[0]  | (w_combo & r_tog);
  assign w_a     = r_stable[8]  | (w_combo & r_tog);
  assign w_l     = r_stable[10] | w_combo;
  assign w_r     = r_stable[11] | w_combo;
`else
  assign w_b = r_stable[0];
  assign w_a = r_stable[8];
  assign w_l = r_stable[10];
  assign w_r = r_stable[11];
`endif

  always_comb begin
    w_nib = 4'hF;
    if      (!r_stable[2]) w_nib = 4'h6;
    else if (!r_stable[3]) w_nib = 4'h9;
    else if (!r_stable[1]) w_nib = 4'hD;
    else if (!r_stable[9]) w_nib = 4'h7;
    else if (!w_l)         w_nib = 4'hC;
    else if (!w_r)         w_nib = 4'h2;
  end

  assign w_j = {w_b, 1'b1, r_stable[6], r_stable[5], r_stable[7], r_stable[4]};
  assign w_k = {w_a, 1'b1, w_nib};

  always_comb begin
    case ({i_c7, i_c4})
      2'b01:   o_lines = w_j;
      2'b10:   o_lines = w_k;
      2'b00:   o_lines = w_j & w_k;
      default: o_lines = 6'h3F;
    endcase
  end
endmodule

module porta_pad_scan #(
  parameter int CLK_DIV        = 4,
  parameter int SCAN_DIV       = 59659,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic       clk,
  input  logic       RESETn,
  output logic       pad_latch,
  output logic       pad_clk,
  input  logic       pad1_data,
  input  logic       pad2_data,
  input  logic       C1_4,
  input  logic       C1_7,
  input  logic       C2_4,
  input  logic       C2_7,
  output logic [5:0] C1_out,
  output logic [5:0] C2_out,
  output logic       scan_done
);
  localparam int IW = $clog2(SCAN_DIV + 1);
  localparam int PW = $clog2(2 * CLK_DIV + 1);
  localparam logic [IW-1:0] IV_LAST = IW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HI   = PW'(CLK_DIV);

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, COMMIT} state_t;

  state_t             r_state, w_nxt_state;
  logic [IW-1:0]      r_ivl, w_ivl_nxt;
  logic [PW-1:0]      r_ph, w_nxt_ph;
  logic [3:0]         r_bit, w_nxt_bit;
  logic               w_sample;
  logic [1:0][11:0]   r_sh;
  logic [1:0]         w_din, w_c4, w_c7;
  logic [1:0][5:0]    w_lines;
  logic               r_latch, r_pclk, r_done;

  assign w_din     = {pad2_data, pad1_data};
  assign w_c4      = {C2_4, C1_4};
  assign w_c7      = {C2_7, C1_7};
  assign w_ivl_nxt = (r_ivl == IV_LAST) ? '0 : r_ivl + IW'(1);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_ph    = r_ph;
    w_nxt_bit   = r_bit;
    w_sample    = 1'b0;
    case (r_state)
      IDLE: if (r_ivl == IV_LAST) begin
        w_nxt_state = LATCH;
        w_nxt_ph    = '0;
        w_nxt_bit   = 4'd0;
      end
      LATCH: if (r_ph == PH_LAST) begin
        w_sample    = 1'b1;
        w_nxt_state = SHIFT;
        w_nxt_ph    = '0;
        w_nxt_bit   = 4'd1;
      end else w_nxt_ph = r_ph + PW'(1);
      SHIFT: if (r_ph == PH_LAST) begin
        w_sample = 1'b1;
        w_nxt_ph = '0;
        if (r_bit == 4'd15) w_nxt_state = COMMIT;
        else                w_nxt_bit   = r_bit + 4'd1;
      end else w_nxt_ph = r_ph + PW'(1);
      default: w_nxt_state = IDLE;
    endcase
  end

  // Pad-facing strobes are registered from next-state so they stay glitch-free and aligned with the FSM.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= IDLE;
      r_ivl   <= '0;
      r_ph    <= '0;
      r_bit   <= '0;
      r_sh    <= '1;
      r_latch <= 1'b0;
      r_pclk  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_ivl   <= w_ivl_nxt;
      r_ph    <= w_nxt_ph;
      r_bit   <= w_nxt_bit;
      if (w_sample && r_bit < 4'd12)
        for (int p = 0; p < 2; p++) r_sh[p][r_bit] <= w_din[p];
      r_latch <= (w_nxt_state == LATCH);
      r_pclk  <= !((w_nxt_state == SHIFT) && (w_nxt_ph < PH_HI));
      r_done  <= (w_nxt_state == COMMIT);
    end
  end

  generate
    for (genvar g = 0; g < 2; g++) begin : g_lane
      porta_pad_lane #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_lane (
        .clk      (clk),
        .RESETn   (RESETn),
        .i_commit (r_done),
        .i_scan   (r_sh[g]),
        .i_c4     (w_c4[g]),
        .i_c7     (w_c7[g]),
        .o_lines  (w_lines[g])
      );
    end
  endgenerate

  assign pad_latch = r_latch;
  assign pad_clk   = r_pclk;
  assign scan_done = r_done;
  assign C1_out    = w_lines[0];
  assign C2_out    = w_lines[1];
endmodule
